// File: rtl/sonar_ctrl.sv
// sonar_ctrl: HC-SR04 sequencer (clk_1m, rst, en/start in, s1_trig/s1_echo sensor, busy/dist_vld/dist_cm/echo_us/timeout result)
module sonar_ctrl #(
  parameter int TRIG_US = 10,
  parameter int ECHO_WAIT_US = 2000,
  parameter int MAX_ECHO_US = 38000,
  parameter int CM_DIV = 58,
  parameter int HOLD_US = 60000
) (
  input  logic        clk_1m,
  input  logic        rst,
  input  logic        en,
  input  logic        start,
  output logic        s1_trig,
  input  logic        s1_echo,
  output logic        busy,
  output logic        dist_vld,
  output logic [9:0]  dist_cm,
  output logic [15:0] echo_us,
  output logic        timeout
);
  typedef enum logic [2:0] {IDLE, TRIG, WAIT, MEAS, DIV, DONE, HOLD} state_t;
  state_t state, state_n;
  logic [15:0] cnt, rem, w, ld_us;
  logic [9:0] q, ld_cm;
  logic e0, e1, e2, ld, ld_to;
  logic [15:0] cnt_p1;
  assign cnt_p1 = cnt + 16'd1;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    ld = 1'b0;
    ld_to = 1'b0;
    ld_cm = q;
    ld_us = w;
    case (state)
      IDLE: state_n = (start | en) ? TRIG : IDLE;
      TRIG: state_n = (cnt == 16'(TRIG_US - 1)) ? WAIT : TRIG;
      WAIT:
        if (e1 & ~e2) state_n = MEAS;
        else if (cnt == 16'(ECHO_WAIT_US - 1)) begin
          state_n = DONE;
          ld = 1'b1;
          ld_to = 1'b1;
          ld_cm = 10'd1023;
          ld_us = 16'd0;
        end
      MEAS:
        if (!e1) state_n = DIV;
        else if (cnt == 16'(MAX_ECHO_US - 1)) begin
          state_n = DONE;
          ld = 1'b1;
          ld_to = 1'b1;
          ld_cm = 10'd1023;
          ld_us = 16'(MAX_ECHO_US);
        end
      DIV:
        if (rem < 16'(CM_DIV)) begin
          state_n = DONE;
          ld = 1'b1;
        end
      DONE: state_n = HOLD;
      HOLD: state_n = (cnt == 16'(HOLD_US - 1)) ? IDLE : HOLD;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_1m) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      {e0, e1, e2} <= '0;
      rem <= '0;
      w <= '0;
      q <= '0;
      s1_trig <= 1'b0;
      dist_vld <= 1'b0;
      dist_cm <= '0;
      echo_us <= '0;
      timeout <= 1'b0;
    end else begin
      state <= state_n;
      {e0, e1, e2} <= {s1_echo, e0, e1};
      cnt <= (state_n != state) ? 16'd0 : cnt_p1;
      // the cycle that detected the rising edge in WAIT was already high, hence cnt+1
      if (state == MEAS && !e1) begin
        w <= cnt_p1;
        rem <= cnt_p1;
        q <= '0;
      end else if (state == DIV && rem >= 16'(CM_DIV)) begin
        rem <= rem - 16'(CM_DIV);
        q <= &q ? q : q + 10'd1;
      end
      s1_trig <= state_n == TRIG;
      dist_vld <= ld;
      if (ld) begin
        dist_cm <= ld_cm;
        echo_us <= ld_us;
        timeout <= ld_to;
      end
    end
  end
endmodule

// File: tb/tb_sonar_ctrl.sv
// tb_sonar_ctrl: directed scoreboard bench for sonar_ctrl
module tb_sonar_ctrl;
  localparam int TRIG = 10, EWAIT = 2000, MAXE = 6000, DIVC = 58, HOLD = 600;
  typedef struct {int cm; int us; int to;} res_t;
  logic clk = 0, rst = 1, en = 0, start = 0, s1_echo = 0;
  logic s1_trig, busy, dist_vld, timeout;
  logic [9:0] dist_cm;
  logic [15:0] echo_us;
  res_t exp_q[$];
  int n_checks = 0, n_fail = 0, vld_cnt = 0, trig_rises = 0, cyc = 0;
  logic trig_q = 0;
  sonar_ctrl #(.TRIG_US(TRIG), .ECHO_WAIT_US(EWAIT), .MAX_ECHO_US(MAXE), .CM_DIV(DIVC), .HOLD_US(HOLD)) dut (
    .clk_1m(clk), .rst(rst), .en(en), .start(start), .s1_trig(s1_trig), .s1_echo(s1_echo),
    .busy(busy), .dist_vld(dist_vld), .dist_cm(dist_cm), .echo_us(echo_us), .timeout(timeout)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_tol(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs + 1 >= exp && obs <= exp + 1) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d (+/-1)", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    res_t e;
    if (s1_trig && !trig_q) trig_rises++;
    trig_q = s1_trig;
    if (dist_vld) begin
      vld_cnt++;
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("dist_cm", 32'(dist_cm), 32'(e.cm));
        chk_tol("echo_us", int'(echo_us), e.us);
        chk("timeout", 32'(timeout), 32'(e.to));
      end
    end
  end
  task automatic push(input int cm, input int us, input int to);
    res_t r;
    r.cm = cm;
    r.us = us;
    r.to = to;
    exp_q.push_back(r);
  endtask
  task automatic pulse_start();
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic wait_trig(input logic lvl, input int lim);
    int n = 0;
    while (s1_trig !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("trig_wait", 32'(s1_trig), 32'(lvl));
  endtask
  task automatic trig_phase(output int hi);
    wait_trig(1'b1, 20);
    hi = 0;
    while (s1_trig === 1'b1 && hi < 100) begin
      @(negedge clk);
      hi++;
    end
  endtask
  task automatic echo_pulse(input int d, input int w);
    repeat (d) @(negedge clk);
    s1_echo = 1;
    repeat (w) @(negedge clk);
    s1_echo = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 10000) begin
      @(negedge clk);
      n++;
    end
    chk("idle", 32'(busy), 32'd0);
  endtask
  initial begin
    int hi, v0, n, tr0;
    int t[3];
    int widths[3] = '{57, 58, 116};
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_trig", 32'(s1_trig), 32'd0);
    chk("rst_vld", 32'(dist_vld), 32'd0);
    chk("rst_outs", 32'({dist_cm, echo_us, timeout}), 32'd0);
    rst = 0;
    @(negedge clk);
    v0 = vld_cnt;
    push(100, 5800, 0);
    pulse_start();
    trig_phase(hi);
    chk("trig_width", 32'(hi), 32'(TRIG));
    echo_pulse(200, 5800);
    wait_idle();
    chk("t1_vld_once", 32'(vld_cnt), 32'(v0 + 1));
    v0 = vld_cnt;
    push(1023, 0, 1);
    pulse_start();
    trig_phase(hi);
    n = 0;
    while (dist_vld !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_to_latency", 32'(n), 32'(EWAIT));
    wait_idle();
    chk("t2_vld_once", 32'(vld_cnt), 32'(v0 + 1));
    push(1023, MAXE, 1);
    pulse_start();
    trig_phase(hi);
    echo_pulse(5, MAXE + 500);
    wait_idle();
    chk("t3_trig_low", 32'(s1_trig), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tr0 = trig_rises;
      push(widths[i] / DIVC, widths[i], 0);
      pulse_start();
      trig_phase(hi);
      if (widths[i] == 116) begin
        repeat (5) @(negedge clk);
        s1_echo = 1;
        repeat (60) @(negedge clk);
        start = 1;
        @(negedge clk);
        start = 0;
        repeat (55) @(negedge clk);
        s1_echo = 0;
      end else echo_pulse(5, widths[i]);
      wait_idle();
      chk("t4_one_trig", 32'(trig_rises), 32'(tr0 + 1));
    end
    en = 1;
    for (int r = 0; r < 3; r++) begin
      push(10, 580, 0);
      wait_trig(1'b1, 2000);
      t[r] = cyc;
      if (r == 2) en = 0;
      wait_trig(1'b0, 50);
      echo_pulse(5, 580);
    end
    wait_idle();
    for (int r = 1; r < 3; r++) begin
      n = t[r] - t[r - 1];
      chk("t5_period_window", 32'(n >= TRIG + 5 + 580 + 13 + HOLD - 4 && n <= TRIG + 5 + 580 + 13 + HOLD + 4), 32'd1);
    end
    chk("t5_period_equal", 32'(t[2] - t[1]), 32'(t[1] - t[0]));
    v0 = vld_cnt;
    pulse_start();
    trig_phase(hi);
    repeat (5) @(negedge clk);
    s1_echo = 1;
    repeat (100) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_trig", 32'(s1_trig), 32'd0);
    chk("t6_vld", 32'(dist_vld), 32'd0);
    chk("t6_outs", 32'({dist_cm, echo_us, timeout}), 32'd0);
    repeat (20) @(negedge clk);
    s1_echo = 0;
    repeat (50) @(negedge clk);
    chk("t6_no_vld", 32'(vld_cnt), 32'(v0));
    push(10, 580, 0);
    pulse_start();
    trig_phase(hi);
    echo_pulse(30, 580);
    wait_idle();
    chk("t6_vld_after", 32'(vld_cnt), 32'(v0 + 1));
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
